muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative signed multiply/divide engine with its own sequencer, fed by the multicycle control unit for MULT, DIV and DIVM.
- The control unit pulses start with operands from the A/B registers, waits for done, and the block produces the 64-bit HI/LO result with a single write strobe.
- Replaces ad-hoc mult_control/DivOp handling with one start/busy/done handshake plus a divide-by-zero flag for the exception path.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.
CNT_W, 6, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  system clock, rising edge.
reset_in  in  1  asynchronous, active-high reset.
start  in  1  request pulse; sampled only in IDLE.
op  in  2  00 MULT, 01 DIV, 10 DIVM (same arithmetic as DIV), 11 reserved.
a_in  in  WIDTH  multiplicand / dividend (signed); sampled with start.
b_in  in  WIDTH  multiplier / divisor (signed); sampled with start.
busy  out  1  high from the cycle after start is accepted until done, inclusive.
done  out  1  one-cycle completion pulse.
div_zero  out  1  one-cycle pulse coincident with done when divisor is 0.
hi_lo_w  out  1  one-cycle HI/LO write strobe, coincident with done on valid results.
hi_out  out  WIDTH  HI result (product high word or remainder).
lo_out  out  WIDTH  LO result (product low word or quotient).

Behaviour:
- Reset, asynchronous, effective immediately:
  - State goes to IDLE and the counter clears.
  - busy, done, div_zero and hi_lo_w go to 0; hi_out and lo_out go to 0.
  - Reset mid-operation abandons the operation and produces no done.
- FSM states: IDLE, LOAD, RUN, FIX, DONE.
- IDLE:
  - start=1 with op≠11 latches op, a_in and b_in, then goes to LOAD.
  - op=11 is ignored and the FSM stays in IDLE.
- LOAD:
  - DIV/DIVM with b=0 goes straight to DONE with div_zero=1.
  - Otherwise the datapath is initialised (Booth product register / magnitudes for division), counter=0, and the FSM goes to RUN.
- RUN:
  - Performs one iteration per cycle and increments the counter.
  - Leaves for FIX when counter reaches WIDTH-1, giving exactly WIDTH cycles.
- FIX:
  - MULT: result is taken unchanged.
  - DIV: quotient is negated if sign(a)≠sign(b); remainder is negated if a<0.
  - Results are registered into hi_out/lo_out, then the FSM goes to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - hi_lo_w=1 unless div_zero; then the FSM returns to IDLE.
  - start in the DONE cycle is ignored; the earliest re-accept is the next IDLE cycle.
- Latency:
  - Count edges from the edge that samples start. done is high in the cycle after edge WIDTH+3, i.e. 35 for WIDTH=32.
  - Divide-by-zero case: done is high after edge 2.
- Arithmetic:
  - MULT: {hi,lo} is the exact signed 2·WIDTH-bit product, computed by radix-2 Booth over the latched operands.
  - DIV: restoring division on magnitudes, truncating toward zero; remainder carries the sign of the dividend.
  - -2^(WIDTH-1) / -1 wraps: lo=0x80000000, hi=0, no flag.
  - On div_zero, hi_out/lo_out keep their previous values.
- busy deasserts in IDLE; start while busy has no effect.
- hi_out/lo_out hold the last written result until the next valid completion.

Decomposition:
- Shared package/header:
  - op encodings OP_MULT=2'b00, OP_DIV=2'b01, OP_DIVM=2'b10.
  - FSM state constants.
  - These match the control unit's ALU op constant style so the control unit can drive op directly.
- One natural sub-module: muldiv_datapath.
  - Holds the Booth product register and the restoring-division remainder/quotient registers.
  - Controlled by init, step and fix strobes; muldiv_sequencer keeps the FSM, counter and handshake.

Test Plan:
- MULT 7 × -3 (a=0x00000007, b=0xFFFFFFFD) -> done/hi_lo_w high after edge 35; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000; busy high for cycles 1..35.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVM 100 / 7 -> lo=14, hi=2.
- Prior result hi=0x11, lo=0x22, then DIV 5 / 0 -> done and div_zero after edge 2; hi_lo_w=0; hi/lo stay 0x11/0x22.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Second start pulse at cycle 10 of a MULT is ignored (single done).
- reset_in asserted mid-RUN -> busy=0, hi/lo=0 without a clock edge, no done; a following MULT 3×4 completes with lo=12.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the iterative multiply/divide engine.
// The op encodings use the same constant style as the control unit's ALU ops,
// so the control unit can drive op without any translation.
package muldiv_sequencer_pkg;

  // Operation select
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_DIVM = 2'b10;  // same arithmetic as OP_DIV
  localparam logic [1:0] OP_RSVD = 2'b11;  // ignored by the sequencer

  // Sequencer FSM states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake/result bundle between the multicycle control unit and the
// multiply/divide engine.
//   master: control unit (drives start/op/a_in/b_in, sees status and results)
//   slave : muldiv_sequencer
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
) ();
  import muldiv_sequencer_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             hi_lo_w;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, div_zero, hi_lo_w, hi_out, lo_out
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, div_zero, hi_lo_w, hi_out, lo_out
  );

endinterface

// File: rtl/muldiv_datapath.sv
// Arithmetic datapath for the multiply/divide engine.
// Holds the radix-2 Booth product register and the restoring-division
// remainder/quotient registers, plus the architectural HI/LO result regs.
//   clk, rst   : clock, async active-high reset
//   init       : load iteration registers from a_op/b_op
//   step       : perform one iteration (both engines step; only one is used)
//   fix        : sign-correct and register the selected result into hi/lo
//   is_mult    : select multiply result on fix, else division result
//   a_op, b_op : latched signed operands (stable for the whole operation)
//   hi_out, lo_out : registered HI/LO result
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             step,
  input  logic             fix,
  input  logic             is_mult,
  input  logic [WIDTH-1:0] a_op,
  input  logic [WIDTH-1:0] b_op,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = a_op[WIDTH-1];
  assign b_neg = b_op[WIDTH-1];
  // Magnitudes as unsigned: |-2^(WIDTH-1)| still fits in WIDTH bits.
  assign a_mag = a_neg ? (~a_op + 1'b1) : a_op;
  assign b_mag = b_neg ? (~b_op + 1'b1) : b_op;

  // ---------------- Booth multiply ----------------
  logic [WIDTH-1:0] acc;     // product high word
  logic [WIDTH-1:0] prod_lo; // product low word / remaining multiplier bits
  logic             q_m1;    // Booth extra bit q[-1]
  logic [WIDTH:0]   sum;     // one extra bit so add/sub of a never overflows

  always_comb begin
    sum = {acc[WIDTH-1], acc};
    case ({prod_lo[0], q_m1})
      2'b10:   sum = {acc[WIDTH-1], acc} - {a_op[WIDTH-1], a_op};
      2'b01:   sum = {acc[WIDTH-1], acc} + {a_op[WIDTH-1], a_op};
      default: sum = {acc[WIDTH-1], acc};
    endcase
  end

  // ---------------- Restoring divide ----------------
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign shifted = {rem, quo[WIDTH-1]};
  // Remainder stays below b_mag, so diff[WIDTH] is a clean borrow flag.
  assign diff    = shifted - {1'b0, b_mag};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      prod_lo <= '0;
      q_m1    <= 1'b0;
      rem     <= '0;
      quo     <= '0;
    end else if (init) begin
      acc     <= '0;
      prod_lo <= b_op;
      q_m1    <= 1'b0;
      rem     <= '0;
      quo     <= a_mag;
    end else if (step) begin
      // Booth: add/sub then arithmetic shift of {acc, prod_lo, q_m1}
      acc     <= sum[WIDTH:1];
      prod_lo <= {sum[0], prod_lo[WIDTH-1:1]};
      q_m1    <= prod_lo[0];
      // Restoring division: keep the trial difference when no borrow
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Truncating division: quotient sign from sign(a)^sign(b), remainder
  // follows the dividend.
  logic [WIDTH-1:0] q_fix, r_fix;
  assign q_fix = (a_neg ^ b_neg) ? (~quo + 1'b1) : quo;
  assign r_fix = a_neg ? (~rem + 1'b1) : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (fix) begin
      hi_out <= is_mult ? acc     : r_fix;
      lo_out <= is_mult ? prod_lo : q_fix;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide engine with start/busy/done handshake.
// Runs MULT (Booth), DIV/DIVM (restoring, truncating) over WIDTH iterations
// and produces HI/LO with a single write strobe; divide-by-zero skips the
// iterations and reports div_zero with done instead of writing HI/LO.
//   clk      : system clock
//   reset_in : async active-high reset; abandons any operation in flight
//   bus      : slave side of muldiv_sequencer_if (start/op/a_in/b_in in,
//              busy/done/div_zero/hi_lo_w/hi_out/lo_out out)
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                reset_in,
  muldiv_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             dz_q;
  logic             busy_q, done_q, div_zero_q, hi_lo_w_q;

  logic accept, is_mult, dz_now;
  logic init, step, fix;

  assign accept  = (state == S_IDLE) && bus.start && (bus.op != OP_RSVD);
  assign is_mult = (op_q == OP_MULT);
  assign dz_now  = !is_mult && (b_q == '0);

  assign init = (state == S_LOAD) && !dz_now;
  assign step = (state == S_RUN);
  assign fix  = (state == S_FIX);

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= OP_MULT;
      a_q        <= '0;
      b_q        <= '0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_lo_w_q  <= 1'b0;
    end else begin
      // Status pulses are registered off the DONE state, so done lands in
      // the first IDLE cycle; busy stays up through that cycle.
      busy_q     <= (state != S_IDLE) || accept;
      done_q     <= (state == S_DONE);
      div_zero_q <= (state == S_DONE) && dz_q;
      hi_lo_w_q  <= (state == S_DONE) && !dz_q;

      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= bus.op;
            a_q   <= bus.a_in;
            b_q   <= bus.b_in;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt  <= '0;
          dz_q <= dz_now;
          state <= dz_now ? S_DONE : S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX:   state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst     (reset_in),
    .init    (init),
    .step    (step),
    .fix     (fix),
    .is_mult (is_mult),
    .a_op    (a_q),
    .b_op    (b_q),
    .hi_out  (bus.hi_out),
    .lo_out  (bus.lo_out)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi_lo_w  = hi_lo_w_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of operations with
// hand-computed HI/LO, flags and latency, plus hand sequences for reserved
// op, start-while-busy and reset mid-operation.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic clk;
  logic reset_in;
  int   n_chk;
  int   n_fail;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one operation; edge 0 samples start, then watches edges 1..45.
  // restart_at > 0 pulses a second (div-by-zero) start at that edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int restart_at, output int lat, output int ndone,
                       output logic [31:0] h, output logic [31:0] l,
                       output logic dz, output logic hw, output logic busy_ok);
    lat = -1; ndone = 0; busy_ok = 1'b1; h = '0; l = '0; dz = 1'b0; hw = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a_in = a; bus.b_in = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (!bus.busy) busy_ok = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin
          lat = k; h = bus.hi_out; l = bus.lo_out; dz = bus.div_zero; hw = bus.hi_lo_w;
        end
      end
      if (lat < 0 || k == lat) begin
        if (!bus.busy) busy_ok = 1'b0;
      end else if (bus.busy) begin
        busy_ok = 1'b0;
      end
      if (k == restart_at) begin
        bus.start = 1'b1; bus.op = OP_DIV; bus.a_in = 32'd1; bus.b_in = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  int          lat, ndone;
  logic [31:0] h, l;
  logic        dz, hw, bok;
  logic        quiet;

  initial begin
    n_chk = 0; n_fail = 0;
    vt[0]  = '{OP_MULT, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35};
    vt[1]  = '{OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 35};
    vt[2]  = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
    vt[3]  = '{OP_DIVM, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 35};
    vt[4]  = '{OP_DIV,  32'd3417,     32'd100,      32'h00000011, 32'h00000022, 1'b0, 35};
    vt[5]  = '{OP_DIV,  32'd5,        32'd0,        32'h00000011, 32'h00000022, 1'b1, 2};
    vt[6]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};
    vt[7]  = '{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 35};
    vt[8]  = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 35};
    vt[9]  = '{OP_MULT, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 35};
    vt[10] = '{OP_DIVM, 32'd0,        32'd5,        32'h00000000, 32'h00000000, 1'b0, 35};
    vt[11] = '{OP_MULT, 32'h00012345, 32'h00000010, 32'h00000000, 32'h00123450, 1'b0, 35};

    bus.start = 1'b0; bus.op = OP_MULT; bus.a_in = '0; bus.b_in = '0;
    reset_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_flags", 64'({bus.div_zero, bus.hi_lo_w}), 64'd0);
    chk("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    @(negedge clk);
    reset_in = 1'b0;

    // Reserved op: no acceptance, no busy, no done.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_RSVD; bus.a_in = 32'd9; bus.b_in = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.done) quiet = 1'b0;
    end
    chk("op11_ignored", 64'(quiet), 64'd1);

    for (int i = 0; i < 12; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, 0, lat, ndone, h, l, dz, hw, bok);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d_ndone", i), 64'(ndone), 64'd1);
      chk($sformatf("v%0d_hi", i), 64'(h), 64'(vt[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(l), 64'(vt[i].lo));
      chk($sformatf("v%0d_div_zero", i), 64'(dz), 64'(vt[i].dz));
      chk($sformatf("v%0d_hi_lo_w", i), 64'(hw), 64'(!vt[i].dz));
      chk($sformatf("v%0d_busy_window", i), 64'(bok), 64'd1);
    end

    // Second start during a MULT is ignored.
    do_op(OP_MULT, 32'h00000007, 32'hFFFFFFFD, 10, lat, ndone, h, l, dz, hw, bok);
    chk("restart_ndone", 64'(ndone), 64'd1);
    chk("restart_latency", 64'(lat), 64'd35);
    chk("restart_result", {h, l}, 64'hFFFFFFFF_FFFFFFEB);
    chk("restart_dz", 64'(dz), 64'd0);

    // Reset mid-RUN: outputs clear without an edge, no done afterwards.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a_in = 32'd5; bus.b_in = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_in = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    @(negedge clk);
    reset_in = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) quiet = 1'b0;
    end
    chk("midrst_no_done", 64'(quiet), 64'd1);

    do_op(OP_MULT, 32'd3, 32'd4, 0, lat, ndone, h, l, dz, hw, bok);
    chk("post_rst_latency", 64'(lat), 64'd35);
    chk("post_rst_result", {h, l}, 64'd12);
    chk("post_rst_hi_lo_w", 64'(hw), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
